// File: rtl/sv_video_pkg.sv
`default_nettype none
// ============================================================================
// sv_video_pkg : shared constants and fetch-state type for the video path
// Revision     : 1.0
// ============================================================================
package sv_video_pkg;

  localparam int BYTES_PER_ROW = 48;
  localparam int FETCH_LEN     = 41;
  localparam int LCD_W         = 160;
  localparam int LCD_H         = 160;
  localparam int VRAM_AW       = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// line_ram : 128x8 simple dual-port line store, registered read port
// Revision : 1.0
// ============================================================================
module line_ram (
  input  logic       clk,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic       re_i,
  input  logic [6:0] raddr_i,
  output logic [7:0] rdata_o
);

  // No reset on storage or read register so the array maps onto block RAM.
  logic [7:0] mem_q [128];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vram_line_fetch.sv
`default_nettype none
// ============================================================================
// vram_line_fetch : prefetches one LCD row of VRAM into a double-buffered
//                   line store and serves 2-bit pixel codes from the other bank
// Revision        : 1.0
// ============================================================================
module vram_line_fetch #(
  parameter int BYTES_PER_ROW = sv_video_pkg::BYTES_PER_ROW,
  parameter int FETCH_LEN     = sv_video_pkg::FETCH_LEN
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             ce,
  input  logic                             line_start,
  input  logic [7:0]                       lcd_line,
  input  logic [7:0]                       lcd_xscroll,
  input  logic [7:0]                       lcd_yscroll,
  output logic                             vram_req,
  output logic [sv_video_pkg::VRAM_AW-1:0] vram_addr,
  input  logic                             vram_gnt,
  input  logic [7:0]                       vram_data,
  input  logic [7:0]                       pix_x,
  output logic [1:0]                       pix,
  output logic                             busy,
  output logic                             underrun
);
  import sv_video_pkg::*;

  localparam logic [5:0] K_LAST = 6'(FETCH_LEN - 1);

  fetch_state_e state_q;
  logic         req_q;
  logic [12:0]  addr_q;
  logic [5:0]   k_q;
  logic [5:0]   w_q;
  logic         beat_q;
  logic         disp_bank_q;
  logic [1:0]   fill_fine_q;
  logic [1:0]   disp_fine_q;
  logic         underrun_q;
  logic         pix_vld_q;
  logic [1:0]   sel_q;

  logic [7:0]   row_d;
  logic [13:0]  pitch_d;
  logic [12:0]  base_d;
  logic [7:0]   p_d;
  logic [7:0]   rd_byte;
  logic [1:0]   pix_sel;

  assign row_d   = lcd_yscroll + lcd_line;
  assign pitch_d = 14'(row_d) * 14'(BYTES_PER_ROW);
  assign base_d  = 13'(pitch_d + {8'b0, lcd_xscroll[7:2]});
  // pix_x <= 159 plus fine <= 3 never exceeds 8 bits.
  assign p_d     = pix_x + {6'b0, disp_fine_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      k_q         <= '0;
      w_q         <= '0;
      beat_q      <= 1'b0;
      disp_bank_q <= 1'b0;
      fill_fine_q <= '0;
      disp_fine_q <= '0;
      underrun_q  <= 1'b0;
      pix_vld_q   <= 1'b0;
      sel_q       <= '0;
    end else if (ce) begin
      beat_q    <= 1'b0;
      pix_vld_q <= 1'b1;
      sel_q     <= p_d[1:0];
      if (beat_q) begin
        w_q <= w_q + 6'd1;
      end
      if (line_start) begin
        if (state_q != IDLE) begin
          underrun_q <= 1'b1;
        end
        disp_bank_q <= ~disp_bank_q;
        disp_fine_q <= fill_fine_q;
        fill_fine_q <= lcd_xscroll[1:0];
        addr_q      <= base_d;
        k_q         <= '0;
        w_q         <= '0;
        req_q       <= 1'b1;
        state_q     <= FETCH;
      end else begin
        case (state_q)
          FETCH: begin
            if (vram_gnt) begin
              beat_q <= 1'b1;
              k_q    <= k_q + 6'd1;
              addr_q <= addr_q + 13'd1;
              if (k_q == K_LAST) begin
                req_q   <= 1'b0;
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (beat_q) begin
              state_q <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  line_ram u_line_ram (
    .clk     (clk),
    .we_i    (ce & beat_q),
    .waddr_i ({~disp_bank_q, w_q}),
    .wdata_i (vram_data),
    .re_i    (ce),
    .raddr_i ({disp_bank_q, p_d[7:2]}),
    .rdata_o (rd_byte)
  );

  always_comb begin
    pix_sel = 2'b00;
    case (sel_q)
      2'd0: pix_sel = rd_byte[1:0];
      2'd1: pix_sel = rd_byte[3:2];
      2'd2: pix_sel = rd_byte[5:4];
      2'd3: pix_sel = rd_byte[7:6];
      default: pix_sel = 2'b00;
    endcase
  end

  assign vram_req  = req_q;
  assign vram_addr = addr_q;
  assign busy      = (state_q != IDLE);
  assign underrun  = underrun_q;
  assign pix       = pix_vld_q ? pix_sel : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_vram_line_fetch.sv
`default_nettype none
// ============================================================================
// tb_vram_line_fetch : directed + randomized bench with a behavioural model
// Revision           : 1.0
// ============================================================================
module tb_vram_line_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  lcd_line = '0, lcd_xscroll = '0, lcd_yscroll = '0;
  logic        vram_req;
  logic [12:0] vram_addr;
  logic        vram_gnt = 1'b0;
  logic [7:0]  vram_data = '0;
  logic [7:0]  pix_x = '0;
  logic [1:0]  pix;
  logic        busy;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  // behavioural model: counts of grants/beats rather than FSM states
  int         m_active, m_granted, m_owed, m_w, m_base;
  int         m_disp_bank, m_fill_fine, m_disp_fine, m_underrun;
  int         m_pix, m_pix_known;
  logic [7:0] m_mem [128];
  bit         m_known [128];

  vram_line_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .line_start  (line_start),
    .lcd_line    (lcd_line),
    .lcd_xscroll (lcd_xscroll),
    .lcd_yscroll (lcd_yscroll),
    .vram_req    (vram_req),
    .vram_addr   (vram_addr),
    .vram_gnt    (vram_gnt),
    .vram_data   (vram_data),
    .pix_x       (pix_x),
    .pix         (pix),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_granted = 0; m_owed = 0; m_w = 0; m_base = 0;
    m_disp_bank = 0; m_fill_fine = 0; m_disp_fine = 0; m_underrun = 0;
    m_pix = 0; m_pix_known = 1;
  endtask

  task automatic model_edge(input bit c, input bit ls, input bit g, input int ln,
                            input int xs, input int ys, input int px, input int d);
    int p, idx;
    bit granted_now;
    if (!c) return;
    p   = px + m_disp_fine;
    idx = m_disp_bank * 64 + p / 4;
    m_pix_known = m_known[idx];
    m_pix = (m_mem[idx] >> (2 * (p % 4))) & 3;
    if (m_owed != 0) begin
      m_mem[(1 - m_disp_bank) * 64 + m_w]   = d[7:0];
      m_known[(1 - m_disp_bank) * 64 + m_w] = 1'b1;
      m_w++;
      m_owed = 0;
    end
    granted_now = (m_active != 0) && (m_granted < 41) && g;
    if (ls) begin
      if (m_active != 0) m_underrun = 1;
      m_disp_bank = 1 - m_disp_bank;
      m_disp_fine = m_fill_fine;
      m_fill_fine = xs % 4;
      m_base      = ((((ys + ln) % 256) * 48) + xs / 4) % 8192;
      m_granted = 0; m_w = 0; m_owed = 0; m_active = 1;
    end else begin
      if (granted_now) begin
        m_granted++;
        m_owed = 1;
      end
      if (m_granted == 41 && m_owed == 0) m_active = 0;
    end
  endtask

  task automatic compare_all();
    int exp_req;
    exp_req = (m_active != 0 && m_granted < 41) ? 1 : 0;
    chk("req", 32'(vram_req), 32'(exp_req));
    if (exp_req != 0) chk("addr", 32'(vram_addr), 32'((m_base + m_granted) % 8192));
    chk("busy", 32'(busy), 32'(m_active));
    chk("underrun", 32'(underrun), 32'(m_underrun));
    if (m_pix_known != 0) chk("pix", 32'(pix), 32'(m_pix));
  endtask

  // Drive one ce-cycle from a negedge, advance the model, check at next negedge.
  task automatic step(input bit c, input bit ls, input bit g, input int ln, input int xs,
                      input int ys, input int px, input int d);
    ce = c; line_start = ls; vram_gnt = g;
    lcd_line = 8'(ln); lcd_xscroll = 8'(xs); lcd_yscroll = 8'(ys);
    pix_x = 8'(px); vram_data = 8'(d);
    model_edge(c, ls, g, ln, xs, ys, px, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic finish_fetch(input string name);
    int n = 0;
    while (busy && n < 300) begin
      step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 128; i++) begin
      m_known[i] = 1'b0;
      m_mem[i]   = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_req", 32'(vram_req), 32'd0);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_pix", 32'(pix), 32'd0);

    // Scroll 0, line 0: addresses 0x000..0x028, busy low 43 cycles after line_start.
    step(1, 1, 1, 0, 0, 0, 0, 0);
    chk("t2_first_addr", 32'(vram_addr), 32'h000);
    for (int i = 1; i <= 40; i++) step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
    chk("t2_last_addr", 32'(vram_addr), 32'h028);
    n = 40;
    while (busy && n < 200) begin
      step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
      n++;
    end
    chk("t2_busy_cycles", 32'(n), 32'd42);

    // yscroll=2, line=3, xscroll=9 -> base 242
    step(1, 1, 1, 3, 9, 2, 0, 0);
    chk("t3_first_addr", 32'(vram_addr), 32'd242);
    for (int i = 1; i <= 40; i++) step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
    chk("t3_last_addr", 32'(vram_addr), 32'd282);
    finish_fetch("t3_done");

    step(1, 1, 1, 0, 0, 200, 0, 0);
    chk("t4_row200_addr", 32'(vram_addr), 32'd1408);
    finish_fetch("t4a_done");
    step(1, 1, 1, 159, 252, 255, 0, 0);
    chk("t4_row158_addr", 32'(vram_addr), 32'd7647);
    finish_fetch("t4b_done");
    // Row 170 starts at 8160 and wraps past 0x1FFF.
    step(1, 1, 1, 0, 0, 170, 0, 0);
    for (int i = 1; i <= 40; i++) step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
    chk("t4_wrap_last", 32'(vram_addr), 32'd8);
    finish_fetch("t4c_done");

    // Fill bytes 0xE4, 0x1B with xscroll=1; data for grant k arrives at step k+2.
    step(1, 1, 1, 0, 1, 0, 0, 0);
    for (int s = 1; s <= 45; s++)
      step(1, 0, 1, 0, 0, 0, 0, (s == 2) ? 8'hE4 : (s == 3) ? 8'h1B : $urandom_range(255));
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("pix_x0", 32'(pix), 32'd1);
    step(1, 0, 1, 0, 0, 0, 1, 0);
    chk("pix_x1", 32'(pix), 32'd2);
    step(1, 0, 1, 0, 0, 0, 2, 0);
    chk("pix_x2", 32'(pix), 32'd3);
    step(1, 0, 1, 0, 0, 0, 3, 0);
    chk("pix_x3", 32'(pix), 32'd3);
    finish_fetch("t5_done");

    // Stall for 10 cycles at k=5 (base 480): completion 10 cycles late.
    step(1, 1, 1, 10, 0, 0, 0, 0);
    for (int s = 1; s <= 5; s++) step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
    for (int s = 6; s <= 15; s++) begin
      step(1, 0, 0, 0, 0, 0, 0, $urandom_range(255));
      chk("stall_addr", 32'(vram_addr), 32'd485);
    end
    n = 15;
    while (busy && n < 300) begin
      step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
      n++;
    end
    chk("stall_cycles", 32'(n), 32'd52);
    chk("stall_no_underrun", 32'(underrun), 32'd0);

    // Abort at k=20 with a new line_start.
    step(1, 1, 1, 20, 8, 0, 0, 0);
    for (int s = 1; s <= 20; s++) step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
    step(1, 1, 1, 20, 0, 1, 0, 0);
    chk("abort_underrun", 32'(underrun), 32'd1);
    chk("abort_addr", 32'(vram_addr), 32'd1008);
    finish_fetch("abort_done");

    // Asynchronous reset mid-fetch.
    step(1, 1, 1, 5, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) step(1, 0, 1, 0, 0, 0, 0, $urandom_range(255));
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(vram_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_underrun", 32'(underrun), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("arst_idle", 32'(busy), 32'd0);

    // Randomized traffic: stalls, ce gaps, occasional early line_start.
    for (int i = 0; i < 4000; i++) begin
      bit c, g, ls;
      c  = ($urandom_range(7) != 0);
      g  = ($urandom_range(3) != 0);
      ls = (m_active != 0) ? ($urandom_range(399) == 0) : ($urandom_range(29) == 0);
      step(c, ls, g, $urandom_range(159), $urandom_range(255), $urandom_range(255),
           $urandom_range(159), $urandom_range(255));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_line_fetch.md
# vram_line_fetch

Line prefetcher between VRAM and the video pixel stage. During each line period it fetches the 41 VRAM bytes needed for the next LCD row into one bank of a double-buffered line store. The video stage reads 2-bit pixel codes from the other bank by LCD x coordinate, which removes per-pixel VRAM access. Scroll registers are sampled once per line, so CPU writes mid-line never tear the image.

## Interface
Parameters:
- BYTES_PER_ROW, 48, VRAM row pitch in bytes (0x30)
- FETCH_LEN, 41, bytes fetched per line (160 px / 4, plus 1 for fine scroll)

Ports (`name  direction  width  meaning`):
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; all state advances only when ce=1
- line_start  in  1  one-ce pulse at start of every LCD line period
- lcd_line  in  8  LCD row (0-159) to fetch, sampled at line_start
- lcd_xscroll  in  8  x scroll, sampled at line_start
- lcd_yscroll  in  8  y scroll, sampled at line_start
- vram_req  out  1  read request
- vram_addr  out  13  read address, valid while vram_req=1
- vram_gnt  in  1  request accepted this cycle
- vram_data  in  8  read data, valid the ce-cycle after gnt
- pix_x  in  8  LCD x (0-159) requested by the video stage
- pix  out  2  pixel code for pix_x on the display bank
- busy  out  1  fetch in progress
- underrun  out  1  sticky: a fetch was aborted by line_start; cleared only by reset

## Operation
- Reset values: vram_req=0, vram_addr=0, pix=0, busy=0, underrun=0, disp_bank=0, state IDLE, all counters 0. Line store contents are undefined (not reset).
- On line_start:
  - toggle disp_bank;
  - latch row = (lcd_yscroll + lcd_line) mod 256, base = row*48 + lcd_xscroll[7:2] (mod 8192), fine = lcd_xscroll[1:0];
  - reset the request counter k and the write counter w; enter FETCH.
- The fetch fills bank ~disp_bank, i.e. the bank opposite the one just made the display bank.
- The latched fine value belongs to the filled bank. It transfers to the display side at the next line_start.
- States:
  - IDLE: vram_req=0, busy=0.
  - FETCH: vram_req=1, vram_addr=(base+k) mod 8192. On gnt, k++. When the gnt for k=FETCH_LEN-1 occurs → DRAIN.
  - DRAIN: vram_req=0. Wait for the last data beat → IDLE.
  - busy=1 in FETCH and DRAIN.
- Every ce-cycle following a granted cycle, write vram_data to line store [fill bank][w], then w++.
- vram_addr and vram_req hold while gnt=0. Any number of stall cycles is allowed.
- line_start while busy: abort and set underrun=1.
  - Any data beat owed from a gnt in the same cycle is discarded.
  - Bank toggle and restart proceed as normal.
  - The display bank then holds a partial line; that is acceptable.
- Pixel read:
  - p = pix_x + disp_fine (9 bits, max 162);
  - byte = line store [disp_bank][p[8:2]];
  - pix = byte[2*p[1:0] +: 2]. Pixel 0 of a byte is in bits [1:0].
- Address arithmetic: row*48 is 14-bit; base and base+k truncate to 13 bits, so the address wraps to 0 after 0x1FFF.

## Timing
- pix is registered: it reflects the pix_x presented on the previous ce-cycle (1-cycle latency).
- Fetch duration with no stalls: line_start + 1 to first req, 41 ce-cycles of requests, +1 for the last write. busy deasserts 43 ce-cycles after line_start.
- Data is written 1 ce-cycle after its gnt.
- line_start is never back-to-back with a read of the same bank. Reads and writes always target opposite banks, so there is no read/write collision.
- ce=0 freezes all state, including a pending data beat (vram_data must be held by the source).

## Structure
- Shared package `sv_video_pkg`: BYTES_PER_ROW, FETCH_LEN, LCD_W=160, LCD_H=160, VRAM_AW=13, and the fetch state enum {IDLE, FETCH, DRAIN}.
- Sub-module `line_ram`: 128x8 simple dual-port RAM (1 write port, 1 registered read port). Address = {bank, idx[5:0]}. Infers block RAM.

## Test plan
- Reset mid-FETCH (reset_n low for 1 cycle) → vram_req=0, busy=0, underrun=0 immediately and asynchronously; IDLE after release.
- yscroll=0, line=0, xscroll=0, gnt tied 1 → vram_addr 0x000..0x028 on consecutive cycles; busy low 43 cycles after line_start.
- yscroll=2, line=3, xscroll=9 → first addr 242 (0x0F2), last 282 (0x11A); fine=1.
- yscroll=200, line=0, xscroll=0 → first addr 9600 mod 8192 = 1408 (0x580); yscroll=255, line=159, xscroll=252 → row 158, addr 7584+63=7647 ascending with 13-bit wrap.
- Fill bytes 0xE4, 0x1B with xscroll=1, then issue line_start → pix for pix_x=0,1,2,3 = 01,10,11,11 (pix_x=3 reads byte1 bits[1:0]=11).
- gnt low for 10 cycles at k=5 → vram_addr holds base+5 throughout; fetch completes 10 cycles late; no underrun. A second line_start at k=20 → underrun=1, restart from new base.
